pipe_ctrl_unit: RTL and testbench

Registered, parametrised decode/control unit for the pipelined core, sitting between the IF/ID and ID/EX pipeline registers. It decodes the ID-stage opcode into the full control bundle and registers it into the EX stage. It detects load-use hazards and inserts bubbles. It runs a halt state machine that drains in-flight instructions before asserting `halted`.

---
 rtl/pipe_ctrl_pkg.sv | 45 ++++
 rtl/pipe_ctrl_unit_ctrl_decode.sv | 74 +++++++
 rtl/pipe_ctrl_unit.sv | 172 +++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode map, halt-state encoding and control bundle for pipe_ctrl_unit.
`timescale 1ns/1ps
package pipe_ctrl_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_PADDSB = 4'h1;
  localparam logic [3:0] OP_SUB    = 4'h2;
  localparam logic [3:0] OP_AND    = 4'h3;
  localparam logic [3:0] OP_NOR    = 4'h4;
  localparam logic [3:0] OP_SLL    = 4'h5;
  localparam logic [3:0] OP_SRL    = 4'h6;
  localparam logic [3:0] OP_SRA    = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LHB    = 4'hA;
  localparam logic [3:0] OP_LLB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_JAL    = 4'hD;
  localparam logic [3:0] OP_JR     = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } halt_state_e;

  typedef struct packed {
    logic reg_dst;
    logic branch;
    logic mem_read;
    logic mem_to_reg;
    logic mem_write;
    logic alu_src;
    logic reg_write;
    logic load_high;
    logic store_word;
    logic jump_al;
    logic jump_r;
    logic halt;
  } ctrl_t;

  localparam ctrl_t BUBBLE = 12'h000;

endpackage

// File: rtl/pipe_ctrl_unit_ctrl_decode.sv
// Combinational opcode decoder: opcode -> control bundle plus illegal flag.
`timescale 1ns/1ps
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] i_opcode,
  output ctrl_t          o_ctrl,
  output logic           o_illegal
);

  logic       w_hi;
  logic [3:0] w_op;

  assign w_op = i_opcode[3:0];

  // Any set bit above the 4-bit opcode space makes the instruction illegal.
  generate
    if (OPW > 4) begin : g_hi
      assign w_hi = |i_opcode[OPW-1:4];
    end else begin : g_nohi
      assign w_hi = 1'b0;
    end
  endgenerate

  assign o_illegal = w_hi;

  // Opcode to control-bit map.
  always_comb begin
    o_ctrl = BUBBLE;
    case (w_op)
      OP_ADD, OP_PADDSB, OP_SUB, OP_AND, OP_NOR, OP_SLL, OP_SRL, OP_SRA: begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      OP_LW: begin
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.store_word = 1'b1;
      end
      OP_SW: begin
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.store_word = 1'b1;
        o_ctrl.reg_dst    = 1'b1;
      end
      OP_LHB: begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.load_high = 1'b1;
      end
      OP_LLB: begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      OP_B:   o_ctrl.branch = 1'b1;
      OP_JAL: begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.jump_al   = 1'b1;
      end
      OP_JR:  o_ctrl.jump_r = 1'b1;
      OP_HLT: o_ctrl.halt   = 1'b1;
      default: o_ctrl = BUBBLE;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID->EX control unit: decode, load-use bubble insertion and halt drain FSM.
// Optional feature macro: PIPE_CTRL_HAZARD_EN enables load-use stall detection.
`timescale 1ns/1ps
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int OPW          = 4,
  parameter int RAW          = 4,
  parameter int LINK_REG     = 15,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_id_valid,
  input  logic [OPW-1:0] i_id_opcode,
  input  logic [RAW-1:0] i_id_rs,
  input  logic [RAW-1:0] i_id_rt,
  input  logic [RAW-1:0] i_id_rd,
  input  logic           i_ex_flush,
  output logic           o_stall,
  output logic           o_fetch_en,
  output logic           o_ex_valid,
  output logic           o_ex_reg_dst,
  output logic           o_ex_branch,
  output logic           o_ex_mem_read,
  output logic           o_ex_mem_to_reg,
  output logic           o_ex_mem_write,
  output logic           o_ex_alu_src,
  output logic           o_ex_reg_write,
  output logic           o_ex_load_high,
  output logic           o_ex_store_word,
  output logic           o_ex_jump_al,
  output logic           o_ex_jump_r,
  output logic           o_ex_halt,
  output logic [OPW-1:0] o_ex_opcode,
  output logic [RAW-1:0] o_ex_dst,
  output logic           o_illegal_op,
  output logic           o_halted
);

  localparam logic [RAW-1:0] LINK     = RAW'(LINK_REG);
  localparam logic [3:0]     CNT_LOAD = 4'(DRAIN_CYCLES - 1);

  ctrl_t          w_dec_ctrl;
  logic           w_dec_illegal;
  logic           w_stall;
  logic           w_load;
  logic           w_illegal_nxt;
  logic [RAW-1:0] w_dst;
  halt_state_e    w_state_nxt;
  logic [3:0]     w_cnt_nxt;

  halt_state_e    r_state;
  logic [3:0]     r_cnt;
  logic           r_ex_valid;
  ctrl_t          r_ex_ctrl;
  logic [OPW-1:0] r_ex_opcode;
  logic [RAW-1:0] r_ex_dst;
  logic           r_illegal;
  logic           r_fetch_en;
  logic           r_halted;

  ctrl_decode #(.OPW(OPW)) u_decode (
    .i_opcode  (i_id_opcode),
    .o_ctrl    (w_dec_ctrl),
    .o_illegal (w_dec_illegal)
  );

`ifdef PIPE_CTRL_HAZARD_EN
  assign w_stall = r_ex_valid & r_ex_ctrl.mem_read & (r_ex_dst != {RAW{1'b0}}) & i_id_valid &
                   ((r_ex_dst == i_id_rs) | (r_ex_dst == i_id_rt));
`else
  logic w_unused_regs;
  assign w_unused_regs = ^{i_id_rs, i_id_rt};
  assign w_stall       = 1'b0;
`endif

  assign w_dst = w_dec_ctrl.jump_al ? LINK : i_id_rd;

  // EX register load select, highest priority first.
  always_comb begin
    w_load        = 1'b0;
    w_illegal_nxt = 1'b0;
    if (r_state != ST_RUN) begin
      w_load = 1'b0;
    end else if (i_ex_flush) begin
      w_load = 1'b0;
    end else if (w_stall) begin
      w_load = 1'b0;
    end else if (!i_id_valid) begin
      w_load = 1'b0;
    end else if (w_dec_illegal) begin
      w_illegal_nxt = 1'b1;
    end else begin
      w_load = 1'b1;
    end
  end

  // Halt FSM next state; DRAIN is entered on the same edge the HLT reaches EX.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_load && w_dec_ctrl.halt) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = CNT_LOAD;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_HALTED;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_HALTED: w_state_nxt = ST_HALTED;
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // EX pipeline registers and halt FSM state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_RUN;
      r_cnt       <= 4'd0;
      r_ex_valid  <= 1'b0;
      r_ex_ctrl   <= BUBBLE;
      r_ex_opcode <= {OPW{1'b0}};
      r_ex_dst    <= {RAW{1'b0}};
      r_illegal   <= 1'b0;
      r_fetch_en  <= 1'b1;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ex_valid  <= w_load;
      r_ex_ctrl   <= w_load ? w_dec_ctrl : BUBBLE;
      r_ex_opcode <= w_load ? i_id_opcode : {OPW{1'b0}};
      r_ex_dst    <= w_load ? w_dst : {RAW{1'b0}};
      r_illegal   <= w_illegal_nxt;
      r_fetch_en  <= (w_state_nxt == ST_RUN);
      r_halted    <= (w_state_nxt == ST_HALTED);
    end
  end

  assign o_stall         = w_stall;
  assign o_fetch_en      = r_fetch_en;
  assign o_ex_valid      = r_ex_valid;
  assign o_ex_reg_dst    = r_ex_ctrl.reg_dst;
  assign o_ex_branch     = r_ex_ctrl.branch;
  assign o_ex_mem_read   = r_ex_ctrl.mem_read;
  assign o_ex_mem_to_reg = r_ex_ctrl.mem_to_reg;
  assign o_ex_mem_write  = r_ex_ctrl.mem_write;
  assign o_ex_alu_src    = r_ex_ctrl.alu_src;
  assign o_ex_reg_write  = r_ex_ctrl.reg_write;
  assign o_ex_load_high  = r_ex_ctrl.load_high;
  assign o_ex_store_word = r_ex_ctrl.store_word;
  assign o_ex_jump_al    = r_ex_ctrl.jump_al;
  assign o_ex_jump_r     = r_ex_ctrl.jump_r;
  assign o_ex_halt       = r_ex_ctrl.halt;
  assign o_ex_opcode     = r_ex_opcode;
  assign o_ex_dst        = r_ex_dst;
  assign o_illegal_op    = r_illegal;
  assign o_halted        = r_halted;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit (OPW=5, DRAIN_CYCLES=3); follows PIPE_CTRL_HAZARD_EN.
`timescale 1ns/1ps
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_opcode;
  logic [3:0] id_rs, id_rt, id_rd;
  logic       ex_flush;
  logic       stall, fetch_en, ex_valid;
  logic       ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src;
  logic       ex_reg_write, ex_load_high, ex_store_word, ex_jump_al, ex_jump_r, ex_halt;
  logic [4:0] ex_opcode;
  logic [3:0] ex_dst;
  logic       illegal_op, halted;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.OPW(5), .RAW(4), .LINK_REG(15), .DRAIN_CYCLES(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_opcode(id_opcode),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_rd(id_rd), .i_ex_flush(ex_flush),
    .o_stall(stall), .o_fetch_en(fetch_en), .o_ex_valid(ex_valid),
    .o_ex_reg_dst(ex_reg_dst), .o_ex_branch(ex_branch), .o_ex_mem_read(ex_mem_read),
    .o_ex_mem_to_reg(ex_mem_to_reg), .o_ex_mem_write(ex_mem_write), .o_ex_alu_src(ex_alu_src),
    .o_ex_reg_write(ex_reg_write), .o_ex_load_high(ex_load_high), .o_ex_store_word(ex_store_word),
    .o_ex_jump_al(ex_jump_al), .o_ex_jump_r(ex_jump_r), .o_ex_halt(ex_halt),
    .o_ex_opcode(ex_opcode), .o_ex_dst(ex_dst), .o_illegal_op(illegal_op), .o_halted(halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id(input logic v, input logic [4:0] op, input logic [3:0] rs,
                    input logic [3:0] rt, input logic [3:0] rd);
    id_valid  = v;
    id_opcode = op;
    id_rs     = rs;
    id_rt     = rt;
    id_rd     = rd;
  endtask

  initial begin
    rst = 1'b1; ex_flush = 1'b0;
    id(1'b0, 5'h00, 4'd0, 4'd0, 4'd0);
    step(); step();
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_fetch_en", {31'd0, fetch_en}, 32'd1);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_ex_bundle", {20'd0, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write,
        ex_alu_src, ex_reg_write, ex_load_high, ex_store_word, ex_jump_al, ex_jump_r, ex_halt}, 32'd0);
    chk("rst_ex_opdst", {23'd0, ex_opcode, ex_dst}, 32'd0);
    chk("rst_illegal", {31'd0, illegal_op}, 32'd0);
    rst = 1'b0;

    // LW r3 then dependent ADD r5 = r3 + r4
    id(1'b1, 5'h08, 4'd1, 4'd2, 4'd3);
    #1 chk("lw_no_stall", {31'd0, stall}, 32'd0);
    step();
    chk("lw_valid", {31'd0, ex_valid}, 32'd1);
    chk("lw_bundle", {20'd0, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write,
        ex_alu_src, ex_reg_write, ex_load_high, ex_store_word, ex_jump_al, ex_jump_r, ex_halt}, 32'hB68);
    chk("lw_dst", {28'd0, ex_dst}, 32'd3);
    id(1'b1, 5'h00, 4'd3, 4'd4, 4'd5);
    #1;
`ifdef PIPE_CTRL_HAZARD_EN
    chk("lu_stall", {31'd0, stall}, 32'd1);
    step();
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_dst", {28'd0, ex_dst}, 32'd0);
    chk("lu_stall_gone", {31'd0, stall}, 32'd0);
    step();
`else
    chk("lu_no_stall", {31'd0, stall}, 32'd0);
    step();
`endif
    chk("add_valid", {31'd0, ex_valid}, 32'd1);
    chk("add_reg_write", {31'd0, ex_reg_write}, 32'd1);
    chk("add_dst", {28'd0, ex_dst}, 32'd5);
    chk("add_mem_read", {31'd0, ex_mem_read}, 32'd0);

    // LW r0 then ADD using r0: never a hazard
    id(1'b1, 5'h08, 4'd0, 4'd0, 4'd0);
    step();
    id(1'b1, 5'h00, 4'd0, 4'd0, 4'd6);
    #1 chk("lw_r0_no_stall", {31'd0, stall}, 32'd0);
    step();
    chk("add2_valid", {31'd0, ex_valid}, 32'd1);
    chk("add2_dst", {28'd0, ex_dst}, 32'd6);

    id(1'b1, 5'h0D, 4'd1, 4'd2, 4'd7);
    step();
    chk("jal_jump_al", {31'd0, ex_jump_al}, 32'd1);
    chk("jal_reg_write", {31'd0, ex_reg_write}, 32'd1);
    chk("jal_dst", {28'd0, ex_dst}, 32'd15);
    chk("jal_opcode", {27'd0, ex_opcode}, 32'h0D);

    id(1'b1, 5'h09, 4'd1, 4'd2, 4'd3);
    ex_flush = 1'b1;
    step();
    chk("flush_bubble", {31'd0, ex_valid}, 32'd0);
    chk("flush_mem_write", {31'd0, ex_mem_write}, 32'd0);
    ex_flush = 1'b0;
    id(1'b0, 5'h09, 4'd1, 4'd2, 4'd3);
    step();
    chk("flush_mem_write2", {31'd0, ex_mem_write}, 32'd0);

    id(1'b1, 5'h10, 4'd0, 4'd0, 4'd1);
    step();
    chk("ill_pulse", {31'd0, illegal_op}, 32'd1);
    chk("ill_bubble", {31'd0, ex_valid}, 32'd0);
    id(1'b0, 5'h00, 4'd0, 4'd0, 4'd0);
    step();
    chk("ill_one_cycle", {31'd0, illegal_op}, 32'd0);

    // Flushed HLT must never halt
    id(1'b1, 5'h0F, 4'd0, 4'd0, 4'd0);
    ex_flush = 1'b1;
    step();
    chk("fhlt_ex_halt", {31'd0, ex_halt}, 32'd0);
    chk("fhlt_fetch_en", {31'd0, fetch_en}, 32'd1);
    ex_flush = 1'b0;
    id(1'b0, 5'h00, 4'd0, 4'd0, 4'd0);
    step(); step(); step(); step();
    chk("fhlt_not_halted", {31'd0, halted}, 32'd0);

    // Real HLT at edge N
    id(1'b1, 5'h0F, 4'd0, 4'd0, 4'd0);
    step();
    chk("hlt_ex_halt", {31'd0, ex_halt}, 32'd1);
    chk("hlt_fetch_en", {31'd0, fetch_en}, 32'd0);
    chk("hlt_n_halted", {31'd0, halted}, 32'd0);
    id(1'b1, 5'h00, 4'd1, 4'd2, 4'd9);
    step();
    chk("hlt_pulse", {31'd0, ex_halt}, 32'd0);
    chk("drain_add_blocked", {31'd0, ex_valid}, 32'd0);
    chk("hlt_n1_halted", {31'd0, halted}, 32'd0);
    ex_flush = 1'b1;
    step();
    chk("hlt_n2_halted", {31'd0, halted}, 32'd0);
    chk("drain_add_blocked2", {31'd0, ex_valid}, 32'd0);
    ex_flush = 1'b0;
    step();
    chk("hlt_n3_halted", {31'd0, halted}, 32'd1);
    step();
    chk("halted_sticky", {31'd0, halted}, 32'd1);
    chk("halted_fetch_en", {31'd0, fetch_en}, 32'd0);
    chk("halted_no_load", {31'd0, ex_valid}, 32'd0);

    rst = 1'b1;
    step();
    chk("rst_halted_clr", {31'd0, halted}, 32'd0);
    chk("rst_fetch_en2", {31'd0, fetch_en}, 32'd1);
    rst = 1'b0;
    step();
    chk("run_after_rst", {31'd0, ex_valid}, 32'd1);
    chk("run_after_rst_dst", {28'd0, ex_dst}, 32'd9);

    // Reset in the middle of DRAIN
    id(1'b1, 5'h0F, 4'd0, 4'd0, 4'd0);
    step();
    id(1'b0, 5'h00, 4'd0, 4'd0, 4'd0);
    step();
    rst = 1'b1;
    step();
    chk("mid_drain_rst_fetch", {31'd0, fetch_en}, 32'd1);
    rst = 1'b0;
    step(); step(); step(); step();
    chk("mid_drain_no_halt", {31'd0, halted}, 32'd0);
    chk("mid_drain_fetch_en", {31'd0, fetch_en}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
